// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares mainMem between two interlocked Request/ACK requesters, round-robin by default.
// Define ARB_FIXED_PRIORITY_EN to make P0 win every tie instead.
module mem_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          P0_Request,
    input  logic          P0_WE,
    input  logic [AW-1:0] P0_Address,
    inout  wire  [DW-1:0] P0_dataBus,
    output logic          P0_ACK,
    input  logic          P1_Request,
    input  logic          P1_WE,
    input  logic [AW-1:0] P1_Address,
    inout  wire  [DW-1:0] P1_dataBus,
    output logic          P1_ACK,
    output logic          MEM_Request,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_Address,
    inout  wire  [DW-1:0] MEM_dataBus,
    input  logic          MEM_ACK
);
    typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_REL, DONE} state_t;

    state_t        r_state, w_next;
    logic          r_gnt, r_last, r_we, r_ack0, r_ack1, r_mem_req;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata, r_rdata;
    logic          w_req0, w_req1, w_win, w_gnt_req;

    assign w_req0    = P0_Request & ~r_ack0;
    assign w_req1    = P1_Request & ~r_ack1;
    assign w_gnt_req = r_gnt ? P1_Request : P0_Request;
`ifdef ARB_FIXED_PRIORITY_EN
    assign w_win = ~w_req0;
`else
    // On a tie the requester not served last wins; a lone requester always wins.
    assign w_win = (w_req0 & w_req1) ? ~r_last : ~w_req0;
`endif

    assign P0_ACK      = r_ack0;
    assign P1_ACK      = r_ack1;
    assign MEM_Request = r_mem_req;
    assign MEM_WE      = r_we;
    assign MEM_Address = r_addr;
    assign MEM_dataBus = (r_state == MEM_REQ && r_we) ? r_wdata : 'z;
    assign P0_dataBus  = (r_ack0 && !r_we) ? r_rdata : 'z;
    assign P1_dataBus  = (r_ack1 && !r_we) ? r_rdata : 'z;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // A MEM_ACK left over from an aborted access blocks new grants until it drops.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (!MEM_ACK && (w_req0 || w_req1)) ? MEM_REQ : IDLE;
            MEM_REQ: w_next = MEM_ACK ? MEM_REL : MEM_REQ;
            MEM_REL: w_next = MEM_ACK ? MEM_REL : DONE;
            DONE:    w_next = w_gnt_req ? DONE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gnt     <= 1'b0;
            r_last    <= 1'b1;
            r_we      <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_mem_req <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_next == MEM_REQ) begin
                    r_gnt     <= w_win;
                    r_we      <= w_win ? P1_WE : P0_WE;
                    r_addr    <= w_win ? P1_Address : P0_Address;
                    r_wdata   <= w_win ? P1_dataBus : P0_dataBus;
                    r_mem_req <= 1'b1;
                end
                MEM_REQ: if (MEM_ACK) begin
                    if (!r_we) r_rdata <= MEM_dataBus;
                    r_mem_req <= 1'b0;
                end
                MEM_REL: if (!MEM_ACK) begin
                    r_ack0 <= ~r_gnt;
                    r_ack1 <= r_gnt;
                end
                DONE: if (!w_gnt_req) begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    r_last <= r_gnt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed table, multi-cycle corner sequences and random traffic
// checked against a word-array memory model with round-robin service order.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req[2], we[2];
    logic [31:0] addr[2], wd[2];
    wire  [31:0] bus0, bus1, mbus;
    logic        ack0, ack1, m_req, m_we;
    logic [31:0] m_addr;
    logic        m_ack = 1'b0;

    mem_bus_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .P0_Request(req[0]), .P0_WE(we[0]), .P0_Address(addr[0]), .P0_dataBus(bus0), .P0_ACK(ack0),
        .P1_Request(req[1]), .P1_WE(we[1]), .P1_Address(addr[1]), .P1_dataBus(bus1), .P1_ACK(ack1),
        .MEM_Request(m_req), .MEM_WE(m_we), .MEM_Address(m_addr), .MEM_dataBus(mbus), .MEM_ACK(m_ack)
    );

    assign bus0 = (req[0] && we[0]) ? wd[0] : 'z;
    assign bus1 = (req[1] && we[1]) ? wd[1] : 'z;

    // Interlocked memory: ACK after lat_cfg extra cycles, released once Request drops.
    logic [31:0] mem[64];
    bit          mem_init, hold_ack;
    int          lat_cfg = 0, m_cnt = 0;
    assign mbus = (m_ack && !m_we) ? mem[m_addr[7:2]] : 'z;
    always @(posedge clk) begin
        if (mem_init) for (int i = 0; i < 64; i++) mem[i] <= 32'(i * 4);
        if (m_req && !m_ack) begin
            if (m_cnt >= lat_cfg) begin
                m_ack <= 1'b1;
                m_cnt <= 0;
                if (m_we) mem[m_addr[7:2]] <= mbus;
            end else m_cnt <= m_cnt + 1;
        end else if (!m_req && m_ack && !hold_ack) m_ack <= 1'b0;
    end

    int errors = 0, checks = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic ack_of(input int p);
        return p != 0 ? ack1 : ack0;
    endfunction
    function automatic logic [31:0] bus_of(input int p);
        return p != 0 ? bus1 : bus0;
    endfunction

    // Protocol monitor: ACK rises only with the memory side quiet, address held through the transaction.
    int          cyc = 0, mreq_rise = -1;
    int          ack_fall[2];
    logic [31:0] mreq_addr = '0;
    logic        mreq_we = 1'b0, p_mreq = 1'b0;
    logic        p_ack[2];
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (m_req && !p_mreq) begin
                mreq_rise = cyc;
                mreq_addr = m_addr;
                mreq_we   = m_we;
            end
            for (int p = 0; p < 2; p++) begin
                if (ack_of(p) && !p_ack[p]) begin
                    chk("ack_rise_mem_quiet", {30'd0, m_req, m_ack}, 32'd0);
                    chk("addr_stable", m_addr, mreq_addr);
                end
                if (!ack_of(p) && p_ack[p]) ack_fall[p] = cyc;
            end
        end
        p_mreq = m_req;
        for (int p = 0; p < 2; p++) p_ack[p] = ack_of(p);
    end

    logic [31:0] model[64];
    bit          model_last;
    logic        t_en[2], t_we[2];
    logic [31:0] t_addr[2], t_wd[2];
    int          t_hold[2];
    bit          glitch_en;
    logic [31:0] glitch_addr;
    logic [31:0] r_rd[2];
    int          r_first, stray, hold_bad;
    bit          r_ok;

    task automatic set_port(input int p, input logic en, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input int h);
        t_en[p] = en; t_we[p] = w; t_addr[p] = a; t_wd[p] = d; t_hold[p] = h;
    endtask

    function automatic int exp_winner(input logic e0, input logic e1);
        if (!(e0 && e1)) return e0 ? 0 : 1;
`ifdef ARB_FIXED_PRIORITY_EN
        return 0;
`else
        return model_last ? 0 : 1;
`endif
    endfunction

    // Plays both requesters; each drops Request t_hold cycles after its ACK and waits for ACK low.
    task automatic run();
        int ph[2], cnt[2];
        r_first = -1; r_ok = 1'b1; stray = 0; hold_bad = 0;
        for (int p = 0; p < 2; p++) begin
            cnt[p] = 0;
            ph[p] = t_en[p] ? 1 : 4;
            if (t_en[p]) begin
                we[p] = t_we[p]; addr[p] = t_addr[p]; wd[p] = t_wd[p]; req[p] = 1'b1;
            end
        end
        for (int c = 0; c < 300 && !(ph[0] == 4 && ph[1] == 4); c++) begin
            @(negedge clk); #1;
            if (glitch_en && m_req && ph[0] == 1) addr[0] = glitch_addr;
            for (int p = 0; p < 2; p++) begin
                if (!t_en[p] && ack_of(p)) stray++;
                if (ph[p] == 1 && ack_of(p)) begin
                    if (r_first < 0) r_first = p;
                    r_rd[p] = bus_of(p);
                    cnt[p] = t_hold[p];
                    ph[p] = 2;
                end else if (ph[p] == 2) begin
                    if (!ack_of(p)) hold_bad++;
                    if (cnt[p] == 0) begin
                        req[p] = 1'b0;
                        ph[p] = 3;
                    end else cnt[p]--;
                end else if (ph[p] == 3 && !ack_of(p)) ph[p] = 4;
            end
        end
        if (!(ph[0] == 4 && ph[1] == 4)) begin
            r_ok = 1'b0;
            req[0] = 1'b0;
            req[1] = 1'b0;
        end
    endtask

    task automatic serve(input string nm);
        int ef, p;
        ef = exp_winner(t_en[0], t_en[1]);
        run();
        chk({nm, "_done"}, {31'd0, r_ok}, 32'd1);
        chk({nm, "_stray_ack"}, stray, 0);
        if (t_en[0] && t_en[1]) chk({nm, "_first"}, r_first, ef);
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? ef : 1 - ef;
            if (t_en[p]) begin
                if (t_we[p]) model[t_addr[p][7:2]] = t_wd[p];
                else chk({nm, "_rdata"}, r_rd[p], model[t_addr[p][7:2]]);
            end
        end
        model_last = (t_en[0] && t_en[1]) ? (ef == 0) : (ef == 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        model_last = 1'b1;
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   bad;
        logic e0, e1;
        tbl[0] = '{0, 1'b0, 32'h04, 32'h0, 32'h04};
        tbl[1] = '{1, 1'b1, 32'h08, 32'h6C, 32'h0};
        tbl[2] = '{1, 1'b0, 32'h08, 32'h0, 32'h6C};
        tbl[3] = '{0, 1'b1, 32'h20, 32'hDEADBEEF, 32'h0};
        tbl[4] = '{1, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF};
        tbl[5] = '{0, 1'b0, 32'h3C, 32'h0, 32'h3C};
        for (int i = 0; i < 64; i++) model[i] = 32'(i * 4);
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wd[p] = '0; p_ack[p] = 1'b0; ack_fall[p] = -1;
        end
        glitch_en = 1'b0; glitch_addr = '0; hold_ack = 1'b0; mem_init = 1'b1; model_last = 1'b1;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        chk("rst_p0_ack", {31'd0, ack0}, 32'd0);
        chk("rst_p1_ack", {31'd0, ack1}, 32'd0);
        chk("rst_mem_req", {31'd0, m_req}, 32'd0);
        chk("rst_mem_we", {31'd0, m_we}, 32'd0);
        chk("rst_mem_addr", m_addr, 32'd0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            lat_cfg = i % 3;
            set_port(tbl[i].port, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].wd, 0);
            set_port(1 - tbl[i].port, 1'b0, 1'b0, 32'h0, 32'h0, 0);
            serve("vec");
            chk("vec_mem_addr", mreq_addr, tbl[i].addr);
            chk("vec_mem_we", {31'd0, mreq_we}, {31'd0, tbl[i].we});
            if (!tbl[i].we) chk("vec_read", r_rd[tbl[i].port], tbl[i].exp);
        end

        do_reset();
        lat_cfg = 1;
        set_port(0, 1'b1, 1'b0, 32'h04, 32'h0, 0);
        set_port(1, 1'b1, 1'b0, 32'h08, 32'h0, 0);
        serve("tie1");
        chk("tie_after_reset_p0_first", r_first, 0);
        serve("tie2");
        chk("tie_repeat_p0_first", r_first, 0);

        set_port(0, 1'b1, 1'b0, 32'h04, 32'h0, 10);
        set_port(1, 1'b1, 1'b1, 32'h14, 32'h55, 0);
        serve("slow");
        chk("slow_ack_held", hold_bad, 0);
        chk("slow_p1_grant_gap", mreq_rise, ack_fall[0] + 1);

        set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 0);
        serve("p0_alone");
        set_port(0, 1'b1, 1'b0, 32'h18, 32'h0, 0);
        set_port(1, 1'b1, 1'b0, 32'h1C, 32'h0, 0);
        serve("tie3");

        set_port(0, 1'b1, 1'b0, 32'h00, 32'h0, 0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 0);
        glitch_en = 1'b1; glitch_addr = 32'h0C;
        serve("glitch");
        glitch_en = 1'b0;
        chk("glitch_mem_addr", mreq_addr, 32'h0);
        chk("glitch_mem_addr_held", m_addr, 32'h0);
        chk("glitch_rdata", r_rd[0], 32'h0);

        hold_ack = 1'b1;
        we[0] = 1'b0; addr[0] = 32'h10; req[0] = 1'b1;
        bad = 0;
        while (!m_ack && bad < 50) begin
            @(negedge clk); #1;
            bad++;
        end
        chk("midrst_mem_ack_seen", {31'd0, m_ack}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("midrst_mem_req", {31'd0, m_req}, 32'd0);
        chk("midrst_p0_ack", {31'd0, ack0}, 32'd0);
        chk("midrst_mem_we", {31'd0, m_we}, 32'd0);
        chk("midrst_mem_addr", m_addr, 32'd0);
        rst_n = 1'b1;
        model_last = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (m_req) bad++;
        end
        chk("midrst_no_grant_while_ack", bad, 0);
        chk("midrst_ack_still_high", {31'd0, m_ack}, 32'd1);
        hold_ack = 1'b0;
        set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 0);
        serve("midrst_retry");

        for (int i = 0; i < 40; i++) begin
            e0 = 1'($urandom % 2);
            e1 = e0 ? 1'($urandom % 2) : 1'b1;
            lat_cfg = $urandom_range(0, 3);
            set_port(0, e0, 1'($urandom % 2), 32'($urandom_range(0, 7)) << 2, $urandom, $urandom_range(0, 2));
            set_port(1, e1, 1'($urandom % 2), 32'($urandom_range(0, 7)) << 2, $urandom, $urandom_range(0, 2));
            serve("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
